tdm_demux_rx: RTL and testbench

Receive end of the team's serial time-division multiplexed link. The transmitter interleaves CHANNELS words of WIDTH bits, MSB first, into one bit stream with a frame-sync marker. This block locks to the marker, steers each bit to the addressed channel slot, and presents each completed word on a per-channel parallel output with a one-cycle valid strobe. It sits at the link input, ahead of per-channel consumers.

---
 rtl/tdm_demux_rx.sv | 180 ++++++++++++++++++
 tb/tb_tdm_demux_rx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_rx.sv
// ---------------------------------------------------------------------------
// tdm_demux_rx
//
// Receive side of the serial TDM link. The transmitter sends CHANNELS words
// of WIDTH bits each, MSB first, in one serial bit stream. The first bit of
// every frame (the MSB of channel 0) is flagged with frame_sync. This block
// locks onto that marker, collects the bits for each time slot, and presents
// each finished word on its own parallel output. A one-cycle strobe marks
// every word update.
//
// Parameters:
//   CHANNELS   time slots per frame (2..16)
//   WIDTH      bits per channel word (2..32)
//
// Ports:
//   clk         rising-edge system clock
//   reset       synchronous, active-high reset
//   din         serial data bit, MSB of each word first
//   din_valid   qualifies din / frame_sync; low means the link stalled
//   frame_sync  high with the first bit of a frame
//   ch_data     channel k word at [k*WIDTH +: WIDTH], registered and held
//   ch_valid    bit k pulses for one cycle when word k updates
//   slot        slot of the next bit to be accepted (0 while hunting)
//   locked      high while aligned to the frame structure
//   frame_done  one-cycle pulse with the last word of a frame
//   sync_err    one-cycle pulse on a missing or misplaced frame_sync
// ---------------------------------------------------------------------------
module tdm_demux_rx #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    localparam int SLOT_W  = $clog2(CHANNELS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         din,
    input  logic                         din_valid,
    input  logic                         frame_sync,
    output logic [CHANNELS*WIDTH-1:0]    ch_data,
    output logic [CHANNELS-1:0]          ch_valid,
    output logic [SLOT_W-1:0]            slot,
    output logic                         locked,
    output logic                         frame_done,
    output logic                         sync_err
);

    localparam int BIT_W = $clog2(WIDTH);

    // The final bit of a word goes straight into ch_data together with the
    // stored bits, so the shift register only has to keep WIDTH-1 bits.
    localparam int SH_W  = WIDTH - 1;

    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WIDTH - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHANNELS - 1);

    typedef enum logic {
        HUNT    = 1'b0,
        RECEIVE = 1'b1
    } state_t;

    state_t                      state_q,      state_d;
    logic [BIT_W-1:0]            bit_cnt_q,    bit_cnt_d;
    logic [SLOT_W-1:0]           slot_q,       slot_d;
    logic [SH_W-1:0]             shift_q,      shift_d;
    logic [CHANNELS*WIDTH-1:0]   ch_data_q,    ch_data_d;
    logic [CHANNELS-1:0]         ch_valid_q,   ch_valid_d;
    logic                        locked_q,     locked_d;
    logic                        frame_done_q, frame_done_d;
    logic                        sync_err_q,   sync_err_d;

    logic at_frame_start;
    logic word_last;
    logic slot_last;

    assign at_frame_start = (slot_q == '0) && (bit_cnt_q == '0);
    assign word_last      = (bit_cnt_q == LAST_BIT);
    assign slot_last      = (slot_q == LAST_SLOT);

    // Next-state logic. Counters, state and the shift register only move on
    // an accepted bit; the strobes default low so they last exactly one cycle
    // whether or not the link is stalled.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        slot_d       = slot_q;
        shift_d      = shift_q;
        ch_data_d    = ch_data_q;
        ch_valid_d   = '0;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    // The marker bit itself is bit 0 of slot 0 of the frame.
                    if (frame_sync) begin
                        state_d   = RECEIVE;
                        shift_d   = SH_W'(din);
                        bit_cnt_d = BIT_W'(1);
                        slot_d    = '0;
                    end
                end

                RECEIVE: begin
                    if (at_frame_start && !frame_sync) begin
                        // The marker did not arrive where it was due: lose lock
                        // and drop this bit.
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                        bit_cnt_d  = '0;
                        slot_d     = '0;
                        shift_d    = '0;
                    end else if (!at_frame_start && frame_sync) begin
                        // Marker arrived early: drop the partial word and treat
                        // this bit as the start of a new frame.
                        sync_err_d = 1'b1;
                        shift_d    = SH_W'(din);
                        bit_cnt_d  = BIT_W'(1);
                        slot_d     = '0;
                    end else if (word_last) begin
                        ch_data_d[slot_q*WIDTH +: WIDTH] = {shift_q, din};
                        ch_valid_d[slot_q]               = 1'b1;
                        bit_cnt_d                        = '0;
                        shift_d                          = '0;
                        if (slot_last) begin
                            frame_done_d = 1'b1;
                            slot_d       = '0;
                        end else begin
                            slot_d = slot_q + 1'b1;
                        end
                    end else begin
                        // Dropping the top bit is harmless: it only ever holds
                        // a stale bit from before the word started.
                        shift_d   = SH_W'({shift_q, din});
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_d = HUNT;
                end
            endcase
        end

        locked_d = (state_d == RECEIVE);
    end

    // State and output registers. Reset clears the delivered words too, so a
    // reset in mid-frame leaves nothing half-valid downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HUNT;
            bit_cnt_q    <= '0;
            slot_q       <= '0;
            shift_q      <= '0;
            ch_data_q    <= '0;
            ch_valid_q   <= '0;
            locked_q     <= 1'b0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            slot_q       <= slot_d;
            shift_q      <= shift_d;
            ch_data_q    <= ch_data_d;
            ch_valid_q   <= ch_valid_d;
            locked_q     <= locked_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign ch_data    = ch_data_q;
    assign ch_valid   = ch_valid_q;
    assign slot       = slot_q;
    assign locked     = locked_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_rx.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux_rx
//
// Directed and random stimulus for tdm_demux_rx. The expected outputs come
// from a frame-position model: it tracks the bit position in the frame as one
// integer, builds each word by arithmetic, and keeps an array of the
// delivered words.
// ---------------------------------------------------------------------------
module tb_tdm_demux_rx;

    localparam int CHANNELS = 4;
    localparam int WIDTH    = 8;
    localparam int SLOT_W   = $clog2(CHANNELS);
    localparam int FRAME_BITS = CHANNELS * WIDTH;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       din;
    logic                       din_valid;
    logic                       frame_sync;
    logic [CHANNELS*WIDTH-1:0]  ch_data;
    logic [CHANNELS-1:0]        ch_valid;
    logic [SLOT_W-1:0]          slot;
    logic                       locked;
    logic                       frame_done;
    logic                       sync_err;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [WIDTH-1:0]    m_data [CHANNELS];
    logic [CHANNELS-1:0] m_valid;
    logic                m_done;
    logic                m_err;
    logic                m_locked;
    int                  m_pos;
    logic [63:0]         m_acc;

    tdm_demux_rx #(
        .CHANNELS (CHANNELS),
        .WIDTH    (WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .ch_data    (ch_data),
        .ch_valid   (ch_valid),
        .slot       (slot),
        .locked     (locked),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock edge with the inputs the DUT saw.
    task automatic modelStep(input bit r, input bit v, input bit d, input bit fs);
        m_valid = '0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        if (r) begin
            for (int k = 0; k < CHANNELS; k++) m_data[k] = '0;
            m_locked = 1'b0;
            m_pos    = 0;
            m_acc    = '0;
        end else if (v) begin
            if (!m_locked) begin
                if (fs) begin
                    m_locked = 1'b1;
                    m_pos    = 1;
                    m_acc    = 64'(d);
                end
            end else if (m_pos == 0 && !fs) begin
                m_err    = 1'b1;
                m_locked = 1'b0;
            end else if (m_pos != 0 && fs) begin
                m_err = 1'b1;
                m_pos = 1;
                m_acc = 64'(d);
            end else begin
                m_acc = m_acc * 2 + 64'(d);
                m_pos = m_pos + 1;
                if (m_pos % WIDTH == 0) begin
                    m_data[m_pos / WIDTH - 1]  = m_acc[WIDTH-1:0];
                    m_valid[m_pos / WIDTH - 1] = 1'b1;
                    m_acc = '0;
                    if (m_pos == FRAME_BITS) begin
                        m_done = 1'b1;
                        m_pos  = 0;
                    end
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [CHANNELS*WIDTH-1:0] exp_vec;
        logic [SLOT_W-1:0]         exp_slot;
        for (int k = 0; k < CHANNELS; k++) exp_vec[k*WIDTH +: WIDTH] = m_data[k];
        exp_slot = SLOT_W'(m_pos / WIDTH);

        checks++;
        assert (ch_data === exp_vec) else begin
            errors++;
            $error("[TB] FAIL %s ch_data observed %h expected %h", tag, ch_data, exp_vec);
        end
        checks++;
        assert (ch_valid === m_valid) else begin
            errors++;
            $error("[TB] FAIL %s ch_valid observed %b expected %b", tag, ch_valid, m_valid);
        end
        checks++;
        assert (frame_done === m_done) else begin
            errors++;
            $error("[TB] FAIL %s frame_done observed %b expected %b", tag, frame_done, m_done);
        end
        checks++;
        assert (sync_err === m_err) else begin
            errors++;
            $error("[TB] FAIL %s sync_err observed %b expected %b", tag, sync_err, m_err);
        end
        checks++;
        assert (locked === m_locked) else begin
            errors++;
            $error("[TB] FAIL %s locked observed %b expected %b", tag, locked, m_locked);
        end
        checks++;
        assert (slot === exp_slot) else begin
            errors++;
            $error("[TB] FAIL %s slot observed %0d expected %0d", tag, slot, exp_slot);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare 1ns later.
    task automatic applyStimulus(input bit r, input bit v, input bit d, input bit fs,
                                 input string tag);
        reset      = r;
        din_valid  = v;
        din        = d;
        frame_sync = fs;
        @(posedge clk);
        modelStep(r, v, d, fs);
        #1;
        checkOutput(tag);
    endtask

    // Send one word MSB first; optional marker on its first bit and optional
    // stall cycle (with random din/frame_sync noise) before every bit.
    task automatic sendWord(input logic [WIDTH-1:0] w, input bit fs_first,
                            input bit stall, input string tag);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (stall)
                applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), tag);
            applyStimulus(1'b0, 1'b1, w[i], fs_first && (i == WIDTH - 1), tag);
        end
    endtask

    task automatic checkConst(input string tag, input logic [63:0] obs,
                              input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] words [CHANNELS];
        logic [WIDTH-1:0] w77;

        words[0] = 8'hA5;
        words[1] = 8'h3C;
        words[2] = 8'hFF;
        words[3] = 8'h01;
        w77      = 8'h77;
        m_locked = 1'b0;
        m_pos    = 0;
        m_acc    = '0;
        m_valid  = '0;
        m_done   = 1'b0;
        m_err    = 1'b0;
        for (int k = 0; k < CHANNELS; k++) m_data[k] = '0;

        // Reset state.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, "reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "reset");
        checkConst("reset_ch_data", 64'(ch_data), 64'h0);
        checkConst("reset_locked", 64'(locked), 64'h0);

        // Pre-lock garbage: random bits without a marker.
        for (int i = 0; i < 13; i++)
            applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, "garbage");
        checkConst("garbage_locked", 64'(locked), 64'h0);

        // Sync lock with continuous valid.
        for (int k = 0; k < CHANNELS; k++) sendWord(words[k], k == 0, 1'b0, "lock");
        checkConst("lock_ch_data", 64'(ch_data), 64'h01FF3CA5);
        checkConst("lock_locked", 64'(locked), 64'h1);

        // Same frame with a stall before every bit.
        for (int k = 0; k < CHANNELS; k++) sendWord(words[k], k == 0, 1'b1, "stall");
        checkConst("stall_ch_data", 64'(ch_data), 64'h01FF3CA5);

        // Missing sync: a whole frame without the marker.
        for (int k = 0; k < CHANNELS; k++)
            sendWord(WIDTH'($urandom), 1'b0, 1'b0, "missing");
        checkConst("missing_ch_data", 64'(ch_data), 64'h01FF3CA5);
        checkConst("missing_locked", 64'(locked), 64'h0);

        // Random frames with random stalls.
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < CHANNELS; k++)
                sendWord(WIDTH'($urandom), k == 0, 1'($urandom_range(0, 1)), "random");

        // Early sync at bit 3 of slot 2, then 0x77 from the marker bit on.
        sendWord(WIDTH'($urandom), 1'b1, 1'b0, "early");
        sendWord(WIDTH'($urandom), 1'b0, 1'b0, "early");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, "early");
        sendWord(w77, 1'b1, 1'b0, "early");
        checkConst("early_ch_data0", 64'(ch_data[7:0]), 64'h77);
        checkConst("early_valid", 64'(ch_valid), 64'h1);
        for (int k = 1; k < CHANNELS; k++)
            sendWord(WIDTH'($urandom), 1'b0, 1'b0, "early");

        // Random noise with occasional markers and stalls.
        for (int i = 0; i < 400; i++)
            applyStimulus(1'b0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 15) == 0, "noise");

        // Reset mid-frame at bit 5 of slot 1, then a clean frame.
        sendWord(WIDTH'($urandom), 1'b1, 1'b0, "midreset");
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, "midreset");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, "midreset");
        checkConst("midreset_ch_data", 64'(ch_data), 64'h0);
        for (int k = 0; k < CHANNELS; k++) sendWord(words[k], k == 0, 1'b0, "clean");
        checkConst("clean_ch_data", 64'(ch_data), 64'h01FF3CA5);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "idle");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
